filt_mac_mc: RTL and testbench

Time-multiplexed, multi-channel serial-MAC FIR filter with run-time programmable coefficients, valid/ready handshakes on both sides, and rounded, saturated output. It serves as the general-purpose decimator/channel-filter core in the DSP chain. Channels share one multiplier and one accumulator, and each channel keeps its own delay line. Symmetric coefficient folding halves the MAC cycles per output.

---
 rtl/filt_pkg.sv | 34 +++
 rtl/filt_rnd_sat.sv | 36 +++
 rtl/filt_mac_mc.sv | 139 +++++++++++++
 tb/tb_filt_mac_mc.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared definitions for the serial-MAC filter family: FSM encoding and width derivations.
package filt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } filt_state_t;

  // Ceiling log2; 0 for v <= 1.
  function automatic int f_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int f_width(input int v);
    return (f_clog2(v) < 1) ? 1 : f_clog2(v);
  endfunction

  // Number of stored coefficients (and MAC cycles per output).
  function automatic int f_coeff_size(input int length, input int symm);
    return (symm != 0) ? (length + 1) / 2 : length;
  endfunction

  function automatic int f_acc_width(input int data_width, input int coeff_width, input int n);
    return data_width + 1 + coeff_width + f_clog2(n);
  endfunction

endpackage

// File: rtl/filt_rnd_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation.
module filt_rnd_sat #(
  parameter int gp_inp_width = 24,
  parameter int gp_shift     = 0,
  parameter int gp_oup_width = 16
) (
  input  logic signed [gp_inp_width-1:0] i_data,
  output logic signed [gp_oup_width-1:0] o_data,
  output logic                           o_sat
);

  // Working width leaves headroom for the rounding add and for a wider output.
  localparam int c_ww = ((gp_inp_width + 1) > (gp_oup_width + 1)) ? gp_inp_width + 1
                                                                   : gp_oup_width + 1;
  localparam int c_hs = (gp_shift > 0) ? gp_shift - 1 : 0;
  localparam logic signed [c_ww-1:0] c_half = (gp_shift > 0) ? (c_ww'(1) << c_hs) : '0;
  localparam logic signed [c_ww-1:0] c_max  = (c_ww'(1) << (gp_oup_width - 1)) - c_ww'(1);
  localparam logic signed [c_ww-1:0] c_min  = -(c_ww'(1) << (gp_oup_width - 1));

  logic signed [c_ww-1:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    shifted = (c_ww'(i_data) + c_half) >>> gp_shift;
    o_sat   = 1'b0;
    o_data  = shifted[gp_oup_width-1:0];
    if (shifted > c_max) begin
      o_data = c_max[gp_oup_width-1:0];
      o_sat  = 1'b1;
    end else if (shifted < c_min) begin
      o_data = c_min[gp_oup_width-1:0];
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/filt_mac_mc.sv
// Multi-channel FIR with one shared multiplier/accumulator, optional symmetric folding,
// programmable coefficients and a registered, rounded, saturated output.
module filt_mac_mc
  import filt_pkg::*;
#(
  parameter int gp_data_width   = 8,
  parameter int gp_coeff_length = 17,
  parameter int gp_coeff_width  = 12,
  parameter int gp_symm         = 1,
  parameter int gp_channels     = 2,
  parameter int gp_shift        = 0,
  parameter int gp_oup_width    = 16
) (
  input  logic                                                        i_clk,
  input  logic                                                        i_rst,
  input  logic                                                        i_valid,
  output logic                                                        o_ready,
  input  logic [f_width(gp_channels)-1:0]                             i_ch,
  input  logic signed [gp_data_width-1:0]                             i_data,
  input  logic                                                        i_coeff_we,
  input  logic [f_width(f_coeff_size(gp_coeff_length, gp_symm))-1:0]  i_coeff_addr,
  input  logic signed [gp_coeff_width-1:0]                            i_coeff_data,
  output logic                                                        o_valid,
  input  logic                                                        i_ready,
  output logic [f_width(gp_channels)-1:0]                             o_ch,
  output logic signed [gp_oup_width-1:0]                              o_data,
  output logic                                                        o_sat
);

  localparam int c_n     = f_coeff_size(gp_coeff_length, gp_symm);
  localparam int c_cw    = f_width(gp_channels);
  localparam int c_aw    = f_width(c_n);
  localparam int c_tw    = f_width(gp_coeff_length);
  localparam int c_dw1   = gp_data_width + 1;
  localparam int c_pw    = gp_data_width + 1 + gp_coeff_width;
  localparam int c_accw  = f_acc_width(gp_data_width, gp_coeff_width, c_n);
  localparam bit c_fold  = (gp_symm != 0);
  localparam bit c_odd   = c_fold && ((gp_coeff_length % 2) == 1);

  filt_state_t state_q, state_d;

  logic        [c_aw-1:0]           k_q;
  logic        [c_cw-1:0]           ch_q;
  logic signed [c_accw-1:0]         acc_q, acc_d;
  logic signed [gp_data_width-1:0]  dly_q   [gp_channels][gp_coeff_length];
  logic signed [gp_coeff_width-1:0] coeff_q [c_n];

  logic        [c_tw-1:0]           tap_a, tap_b;
  logic signed [c_dw1-1:0]          pre;
  logic signed [c_pw-1:0]           prod;
  logic signed [gp_oup_width-1:0]   rs_data;
  logic                             rs_sat;
  logic                             accept, ch_ok, last_k, coeff_wr;

  assign ch_ok    = int'(i_ch) < gp_channels;
  assign accept   = i_valid && o_ready;
  assign last_k   = (k_q == c_aw'(c_n - 1));
  assign coeff_wr = i_coeff_we && (state_q == ST_IDLE) && (int'(i_coeff_addr) < c_n);

  // One MAC term per cycle; folded taps share a coefficient, odd middle tap stands alone.
  always_comb begin
    tap_a = c_tw'(k_q);
    tap_b = c_tw'(gp_coeff_length - 1) - tap_a;
    pre   = c_dw1'(dly_q[ch_q][tap_a]);
    if (c_fold && !(c_odd && last_k)) begin
      pre = c_dw1'(dly_q[ch_q][tap_a]) + c_dw1'(dly_q[ch_q][tap_b]);
    end
    prod  = c_pw'(pre) * c_pw'(coeff_q[k_q]);
    acc_d = acc_q + c_accw'(prod);
  end

  filt_rnd_sat #(
    .gp_inp_width (c_accw),
    .gp_shift     (gp_shift),
    .gp_oup_width (gp_oup_width)
  ) u_rnd_sat (
    .i_data (acc_d),
    .o_data (rs_data),
    .o_sat  (rs_sat)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && ch_ok) state_d = ST_ACC;
      ST_ACC:  if (last_k)          state_d = ST_OUT;
      ST_OUT:  if (i_ready)         state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  assign o_ready = (state_q == ST_IDLE) && !i_rst;
  assign o_valid = (state_q == ST_OUT);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: delay lines and coefficients are reset on purpose; reset must wipe all history.
      for (int c = 0; c < gp_channels; c++) begin
        for (int t = 0; t < gp_coeff_length; t++) dly_q[c][t] <= '0;
      end
      for (int i = 0; i < c_n; i++) coeff_q[i] <= '0;
      k_q    <= '0;
      ch_q   <= '0;
      acc_q  <= '0;
      o_data <= '0;
      o_ch   <= '0;
      o_sat  <= 1'b0;
    end else begin
      if (coeff_wr) coeff_q[i_coeff_addr] <= i_coeff_data;
      unique case (state_q)
        ST_IDLE: begin
          if (accept && ch_ok) begin
            for (int t = gp_coeff_length - 1; t > 0; t--) dly_q[i_ch][t] <= dly_q[i_ch][t-1];
            dly_q[i_ch][0] <= i_data;
            ch_q  <= i_ch;
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        ST_ACC: begin
          acc_q <= acc_d;
          k_q   <= k_q + c_aw'(1);
          if (last_k) begin
            o_data <= rs_data;
            o_ch   <= ch_q;
            o_sat  <= rs_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filt_mac_mc.sv
// Bench for filt_mac_mc: three configurations checked against hand vectors and a
// plain-arithmetic FIR model driven with random stimulus.
module tb_filt_mac_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              t_rst = 1'b1, t_valid = 1'b0, t_we = 1'b0, t_ready = 1'b1;
  logic [1:0]        t_ch = '0, t_addr = '0;
  logic signed [7:0]  t_data = '0;
  logic signed [11:0] t_cdata = '0;
  int sel = 0;

  logic a_ready, a_valid, a_sat, b_ready, b_valid, b_sat, c_ready, c_valid, c_sat;
  logic a_ch, b_ch;
  logic [1:0] c_ch;
  logic signed [15:0] a_data, c_data;
  logic signed [7:0]  b_data;

  logic mo_ready, mo_valid, mo_sat;
  logic [1:0] mo_ch;
  logic signed [15:0] mo_data;

  filt_mac_mc #(.gp_data_width(8), .gp_coeff_length(5), .gp_coeff_width(12), .gp_symm(1),
                .gp_channels(2), .gp_shift(0), .gp_oup_width(16)) u_dut_a (
    .i_clk(clk), .i_rst(t_rst), .i_valid(t_valid && (sel == 0)), .o_ready(a_ready),
    .i_ch(t_ch[0]), .i_data(t_data), .i_coeff_we(t_we && (sel == 0)), .i_coeff_addr(t_addr),
    .i_coeff_data(t_cdata), .o_valid(a_valid), .i_ready(t_ready), .o_ch(a_ch),
    .o_data(a_data), .o_sat(a_sat));

  filt_mac_mc #(.gp_data_width(8), .gp_coeff_length(5), .gp_coeff_width(12), .gp_symm(1),
                .gp_channels(2), .gp_shift(2), .gp_oup_width(8)) u_dut_b (
    .i_clk(clk), .i_rst(t_rst), .i_valid(t_valid && (sel == 1)), .o_ready(b_ready),
    .i_ch(t_ch[0]), .i_data(t_data), .i_coeff_we(t_we && (sel == 1)), .i_coeff_addr(t_addr),
    .i_coeff_data(t_cdata), .o_valid(b_valid), .i_ready(t_ready), .o_ch(b_ch),
    .o_data(b_data), .o_sat(b_sat));

  filt_mac_mc #(.gp_data_width(8), .gp_coeff_length(4), .gp_coeff_width(12), .gp_symm(0),
                .gp_channels(3), .gp_shift(0), .gp_oup_width(16)) u_dut_c (
    .i_clk(clk), .i_rst(t_rst), .i_valid(t_valid && (sel == 2)), .o_ready(c_ready),
    .i_ch(t_ch), .i_data(t_data), .i_coeff_we(t_we && (sel == 2)), .i_coeff_addr(t_addr),
    .i_coeff_data(t_cdata), .o_valid(c_valid), .i_ready(t_ready), .o_ch(c_ch),
    .o_data(c_data), .o_sat(c_sat));

  always_comb begin
    mo_ready = c_ready; mo_valid = c_valid; mo_sat = c_sat; mo_ch = c_ch; mo_data = c_data;
    if (sel == 0) begin
      mo_ready = a_ready; mo_valid = a_valid; mo_sat = a_sat; mo_ch = {1'b0, a_ch}; mo_data = a_data;
    end else if (sel == 1) begin
      mo_ready = b_ready; mo_valid = b_valid; mo_sat = b_sat; mo_ch = {1'b0, b_ch};
      mo_data = 16'(b_data);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: the full L-tap impulse response of each configuration.
  int cfg_l  [3] = '{5, 5, 4};
  int cfg_n  [3] = '{3, 3, 4};
  int cfg_sy [3] = '{1, 1, 0};
  int cfg_sh [3] = '{0, 2, 0};
  int cfg_ow [3] = '{16, 8, 16};
  int cfg_ch [3] = '{2, 2, 3};
  longint m_coef [3][4];
  longint m_hist [3][3][5];

  function automatic void model_clear();
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 4; a++) m_coef[s][a] = 0;
      for (int c = 0; c < 3; c++) for (int t = 0; t < 5; t++) m_hist[s][c][t] = 0;
    end
  endfunction

  function automatic void model_write(input int a, input int d);
    if (a < cfg_n[sel]) m_coef[sel][a] = d;
  endfunction

  function automatic void model_push(input int ch, input int x);
    for (int t = 4; t > 0; t--) m_hist[sel][ch][t] = m_hist[sel][ch][t-1];
    m_hist[sel][ch][0] = x;
  endfunction

  function automatic void model_out(input int ch, output int d, output bit s);
    longint y, mx, mn;
    int len, idx;
    len = cfg_l[sel];
    y = 0;
    for (int i = 0; i < len; i++) begin
      idx = i;
      if (cfg_sy[sel] != 0 && (len - 1 - i) < i) idx = len - 1 - i;
      y += m_coef[sel][idx] * m_hist[sel][ch][i];
    end
    if (cfg_sh[sel] > 0) y = (y + (64'sd1 << (cfg_sh[sel] - 1))) >>> cfg_sh[sel];
    mx = (64'sd1 << (cfg_ow[sel] - 1)) - 1;
    mn = -(64'sd1 << (cfg_ow[sel] - 1));
    s = 1'b0;
    d = int'(y);
    if (y > mx) begin d = int'(mx); s = 1'b1; end
    else if (y < mn) begin d = int'(mn); s = 1'b1; end
  endfunction

  task automatic do_reset();
    t_rst = 1'b1; t_valid = 1'b0; t_we = 1'b0; t_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", mo_valid, 0);
    check("rst_ready", mo_ready, 0);
    check("rst_data", mo_data, 0);
    check("rst_ch", mo_ch, 0);
    check("rst_sat", mo_sat, 0);
    t_rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("ready_after_rst", mo_ready, 1);
  endtask

  task automatic write_coeff(input int a, input int d);
    t_we = 1'b1; t_addr = a[1:0]; t_cdata = d[11:0];
    @(negedge clk);
    t_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic load_coeffs(input int c0, input int c1, input int c2, input int c3);
    int c [4];
    c = '{c0, c1, c2, c3};
    for (int a = 0; a < cfg_n[sel]; a++) write_coeff(a, c[a]);
  endtask

  // Accept one sample (optionally with a same-cycle or mid-ACC coefficient write),
  // check latency and result against the model, optionally stall the output.
  task automatic send(input int ch, input int x, input int stall, input bit we,
                      input int wa, input int wd, input bit acc_we,
                      output int got_d, output bit got_s, output int got_c);
    int n, lat, exp_d;
    bit exp_s;
    n = 0;
    while (!mo_ready && n < 20) begin @(negedge clk); n++; end
    check("ready_idle", mo_ready, 1);
    t_valid = 1'b1; t_ch = ch[1:0]; t_data = x[7:0];
    t_we = we; t_addr = wa[1:0]; t_cdata = wd[11:0];
    t_ready = (stall == 0);
    @(negedge clk);
    t_valid = 1'b0; t_we = 1'b0;
    if (we) model_write(wa, wd);
    got_d = 0; got_s = 1'b0; got_c = 0;
    if (ch >= cfg_ch[sel]) begin
      check("drop_ready", mo_ready, 1);
      check("drop_valid", mo_valid, 0);
      return;
    end
    model_push(ch, x);
    model_out(ch, exp_d, exp_s);
    if (acc_we) begin t_we = 1'b1; t_addr = wa[1:0]; t_cdata = wd[11:0]; end
    lat = 0;
    while (!mo_valid && lat < 100) begin @(negedge clk); t_we = 1'b0; lat++; end
    t_we = 1'b0;
    check("latency", lat, cfg_n[sel]);
    check("model_data", mo_data, exp_d);
    check("model_sat", mo_sat, exp_s);
    check("model_ch", mo_ch, ch);
    got_d = int'(mo_data); got_s = mo_sat; got_c = int'(mo_ch);
    for (int i = 0; i < stall; i++) begin
      t_valid = 1'b1; t_ch = 2'd0; t_data = 8'sd7;
      @(negedge clk);
      check("hold_valid", mo_valid, 1);
      check("hold_data", mo_data, got_d);
      check("hold_ch", mo_ch, got_c);
      check("hold_ready", mo_ready, 0);
    end
    t_valid = 1'b0; t_ready = 1'b1;
    @(negedge clk);
    check("post_valid", mo_valid, 0);
    check("post_ready", mo_ready, 1);
  endtask

  typedef struct {
    int sel;
    bit prep;
    int c [4];
    int ch;
    int x;
    int ed;
    bit es;
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input int s, input bit p, input int c0, input int c1, input int c2,
                              input int c3, input int ch, input int x, input int ed, input bit es);
    vec_t v;
    v.sel = s; v.prep = p; v.c = '{c0, c1, c2, c3};
    v.ch = ch; v.x = x; v.ed = ed; v.es = es;
    vecs.push_back(v);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1);
  end

  initial begin
    int gd, gc;
    bit gs;

    // Impulse, single channel: symmetric L=5, coeff {1,2,3}.
    add(0, 1, 1, 2, 3, 0, 0, 10, 10, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 20, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 30, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 20, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 10, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0,  0, 0);
    // Channel isolation, interleaved impulses.
    add(0, 1, 1, 2, 3, 0, 0, 10,  10, 0);
    add(0, 0, 0, 0, 0, 0, 1, -4,  -4, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0,  20, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0,  -8, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0,  30, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0, -12, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0,  20, 0);
    add(0, 0, 0, 0, 0, 0, 1,  0,  -8, 0);
    // Round half up and saturation, shift 2 into 8 bits.
    add(1, 1, 1, 0, 0, 0, 0,    6,    2, 0);
    add(1, 0, 0, 0, 0, 0, 0,   -6,   -1, 0);
    add(1, 1, 2047, 2047, 2047, 0, 0,  127,  127, 1);
    add(1, 0, 0, 0, 0, 0, 0,  127,  127, 1);
    add(1, 1, 2047, 2047, 2047, 0, 0, -128, -128, 1);
    // Even-length direct form with three channels.
    add(2, 1, 1, 2, 3, 4, 2, 5,  5, 0);
    add(2, 0, 0, 0, 0, 0, 0, 1,  1, 0);
    add(2, 0, 0, 0, 0, 0, 2, 0, 10, 0);
    add(2, 0, 0, 0, 0, 0, 2, 0, 15, 0);
    add(2, 0, 0, 0, 0, 0, 0, 0,  2, 0);
    add(2, 0, 0, 0, 0, 0, 2, 0, 20, 0);
    add(2, 0, 0, 0, 0, 0, 2, 0,  0, 0);

    model_clear();
    do_reset();

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      if (vecs[i].prep) begin
        do_reset();
        load_coeffs(vecs[i].c[0], vecs[i].c[1], vecs[i].c[2], vecs[i].c[3]);
      end
      send(vecs[i].ch, vecs[i].x, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
      check($sformatf("vec%0d_data", i), gd, vecs[i].ed);
      check($sformatf("vec%0d_sat", i), gs, vecs[i].es);
      check($sformatf("vec%0d_ch", i), gc, vecs[i].ch);
    end

    // Backpressure: output held 10 cycles while a new sample waits unconsumed.
    sel = 0;
    do_reset();
    load_coeffs(1, 2, 3, 0);
    send(1, 25, 10, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    check("bp_data", gd, 25);
    send(1, 0, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    check("bp_next", gd, 50);

    // Coefficient write guards.
    do_reset();
    load_coeffs(1, 2, 3, 0);
    write_coeff(3, 500);
    send(0, 10, 0, 1'b0, 1, 100, 1'b1, gd, gs, gc);
    check("guard_first", gd, 10);
    send(0, 0, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    check("guard_acc_write_ignored", gd, 20);
    send(0, 0, 0, 1'b1, 2, 7, 1'b0, gd, gs, gc);
    check("same_cycle_write", gd, 70);

    // Reset in the middle of ACC.
    do_reset();
    load_coeffs(1, 2, 3, 0);
    send(0, 50, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    send(1, -30, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    t_valid = 1'b1; t_ch = 2'd0; t_data = 8'sd40;
    @(negedge clk);
    t_valid = 1'b0;
    @(negedge clk);
    t_rst = 1'b1;
    #1;
    check("mr_ready_in_rst", mo_ready, 0);
    @(negedge clk);
    t_rst = 1'b0;
    model_clear();
    @(negedge clk);
    check("mr_ready_after", mo_ready, 1);
    check("mr_valid_after", mo_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mr_no_valid", mo_valid, 0);
    end
    load_coeffs(1, 2, 3, 0);
    send(0, 10, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    check("mr_impulse0", gd, 10);
    send(0, 0, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    check("mr_impulse1", gd, 20);

    // Coefficients reset to zero, and an out-of-range channel is dropped.
    sel = 2;
    do_reset();
    send(2, 100, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    check("zero_coeff_out", gd, 0);
    load_coeffs(1, 2, 3, 4);
    send(3, 99, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    send(0, 9, 0, 1'b0, 0, 0, 1'b0, gd, gs, gc);
    check("after_drop", gd, 9);

    // Randomized traffic against the model for every configuration.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      for (int a = 0; a < cfg_n[s]; a++) write_coeff(a, int'($urandom_range(0, 4095)) - 2048);
      for (int i = 0; i < 20; i++) begin
        send(int'($urandom_range(0, (s == 2) ? 3 : 1)), int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4095)) - 2048, 1'b0, gd, gs, gc);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
